// File: rtl/fa4_rca_adder.sv
// fa4_rca_adder: WIDTH-bit ripple-carry adder, registered sum/carry/overflow/zero; 1-cycle latency,
// 2 with FA4_RCA_PIPE_EN (input register stage); accepts one operand set per cycle, no backpressure.

module fa4_rca_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module fa4_rca_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_cin;
  logic             core_valid;

`ifdef FA4_RCA_PIPE_EN
  // Operands are only captured when valid, so idle-cycle garbage never enters the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      core_cin   <= 1'b0;
    end else begin
      core_valid <= in_valid;
      if (in_valid) begin
        core_a   <= a;
        core_b   <= b;
        core_cin <= cin;
      end
    end
  end
`else
  assign core_a     = a;
  assign core_b     = b;
  assign core_cin   = cin;
  assign core_valid = in_valid;
`endif

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = core_cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa4_rca_adder_cell u_cell (
        .a  (core_a[i]),
        .b  (core_b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Signed overflow is the disagreement between carry into and out of the MSB cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= core_valid;
      if (core_valid) begin
        sum      <= s;
        carry    <= c[WIDTH];
        overflow <= c[WIDTH] ^ c[WIDTH-1];
        zero     <= ~|s;
      end
    end
  end

endmodule

// File: tb/tb_fa4_rca_adder.sv
// Scoreboard bench for fa4_rca_adder: stimulus pushes reference results, a negedge monitor pops and checks.
module tb_fa4_rca_adder;
  localparam int W = 4;
`ifdef FA4_RCA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;
    logic         zero;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t last;

  fa4_rca_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range test.
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    exp_t e;
    int   u;
    int   sa;
    int   sb_i;
    int   ss;
    u        = int'(ai) + int'(bi) + int'(ci);
    e.sum    = u[W-1:0];
    e.carry  = u[W];
    sa       = (int'(ai) >= (1 << (W-1))) ? int'(ai) - (1 << W) : int'(ai);
    sb_i     = (int'(bi) >= (1 << (W-1))) ? int'(bi) - (1 << W) : int'(bi);
    ss       = sa + sb_i + int'(ci);
    e.overflow = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    e.zero   = (e.sum == '0);
    e.cyc    = 0;
    return e;
  endfunction

  task automatic issue(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    a = ai;
    b = bi;
    cin = ci;
    if (v) begin
      e = model(ai, bi, ci);
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_sum"}, 32'(sum), 0);
    chk({nm, "_carry"}, 32'(carry), 0);
    chk({nm, "_ovf"}, 32'(overflow), 0);
    chk({nm, "_zero"}, 32'(zero), 0);
  endtask

  // Monitor: every valid output must match the oldest pending result at exactly LAT cycles;
  // idle cycles must hold the previous result.
  initial begin
    exp_t e;
    last = '{sum: '0, carry: 1'b0, overflow: 1'b0, zero: 1'b0, cyc: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '{sum: '0, carry: 1'b0, overflow: 1'b0, zero: 1'b0, cyc: 0};
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("latency", 32'(cyc), 32'(e.cyc + LAT));
          chk("sum", 32'(sum), 32'(e.sum));
          chk("carry", 32'(carry), 32'(e.carry));
          chk("overflow", 32'(overflow), 32'(e.overflow));
          chk("zero", 32'(zero), 32'(e.zero));
          last = e;
        end
      end else begin
        chk("hold_sum", 32'(sum), 32'(last.sum));
        chk("hold_carry", 32'(carry), 32'(last.carry));
        chk("hold_ovf", 32'(overflow), 32'(last.overflow));
        chk("hold_zero", 32'(zero), 32'(last.zero));
      end
    end
  end

  initial begin
    // Reset held with live valid traffic: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      chk_cleared("reset_hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;

    // Directed corner cases.
    issue(1, 4'hF, 4'h0, 1'b1);
    issue(1, 4'hF, 4'hF, 1'b1);
    issue(1, 4'h7, 4'h1, 1'b0);
    issue(1, 4'h8, 4'h8, 1'b0);
    issue(1, 4'h3, 4'h5, 1'b0);
    issue(1, 4'h5, 4'hA, 1'b1);
    issue(1, 4'h0, 4'h0, 1'b0);
    issue(0, 4'h0, 4'h0, 1'b0);
    issue(0, 4'h0, 4'h0, 1'b0);

    // Exhaustive, back-to-back.
    for (int ia = 0; ia < (1 << W); ia++)
      for (int ib = 0; ib < (1 << W); ib++)
        for (int ic = 0; ic < 2; ic++)
          issue(1, W'(ia), W'(ib), 1'(ic));
    issue(0, 4'h0, 4'h0, 1'b0);

    // Valid gating: single pulse then idle garbage operands.
    issue(1, 4'h6, 4'h9, 1'b0);
    for (int i = 0; i < 6; i++)
      issue(0, W'($urandom), W'($urandom), 1'($urandom));

    // Random traffic with random valid gaps.
    for (int i = 0; i < 300; i++)
      issue(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));

    // Asynchronous reset mid-stream discards the in-flight result.
    issue(1, 4'h9, 4'h9, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_cleared("async_reset");
    sb.delete();
    @(posedge clk);
    #1;
    chk_cleared("async_reset_held");
    rst = 1'b0;

    // First transaction after reset release.
    issue(1, 4'hC, 4'h4, 1'b0);
    issue(1, 4'h1, 4'h2, 1'b1);
    for (int i = 0; i < LAT + 3; i++)
      issue(0, 4'h0, 4'h0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
